// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of a five-stage RISC-V style pipeline. It holds the
// program counter and the IF/ID pipeline register. A small three-state
// controller (BOOT -> RUN, plus a sticky FAULT) guards the fetch. Redirect
// targets are checked for 4-byte alignment on bit 1 before the PC is updated.
//
// Parameters
//   DATA_WIDTH    width of every address / immediate port
//   RESET_PC      PC value loaded on reset
//
// Ports
//   clk            in   single clock, rising edge
//   rst            in   synchronous active-high reset
//   StallF         in   hold the PC and the IF/ID register
//   FlushD         in   replace the IF/ID contents with a bubble
//   PCSrc[1:0]     in   00 PC+4, 01 PCE+ImmExt, 10 ALUResult (bit 0 cleared),
//                       11 behaves as 00
//   PCE            in   PC of the redirecting instruction
//   ImmExt         in   sign-extended immediate
//   ALUResult      in   jalr target before bit-0 masking
//   InstrF[31:0]   in   instruction-memory read data for PCF (combinational)
//   PCF            out  current fetch address
//   InstrD         out  IF/ID instruction (NOP bubble when not valid)
//   PCD            out  IF/ID PC
//   PCPlus4D       out  IF/ID PC + 4
//   ValidD         out  InstrD holds a real fetched instruction
//   MisalignFault  out  high while the controller sits in FAULT
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallF,
    input  logic                  FlushD,
    input  logic [1:0]            PCSrc,
    input  logic [DATA_WIDTH-1:0] PCE,
    input  logic [DATA_WIDTH-1:0] ImmExt,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [31:0]           InstrF,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [31:0]           InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD,
    output logic                  MisalignFault
);

    // addi x0, x0, 0 -- the canonical bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [DATA_WIDTH-1:0] PC_STEP  = {{(DATA_WIDTH-3){1'b0}}, 3'b100};
    localparam logic [DATA_WIDTH-1:0] PC_ZERO  = {DATA_WIDTH{1'b0}};
    // Clears bit 0 of a jalr target
    localparam logic [DATA_WIDTH-1:0] JALR_MASK = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } state_t;

    // True for the two PCSrc codes that redirect the fetch
    function automatic logic is_redirect(input logic [1:0] sel);
        logic hit;
        case (sel)
            2'b01:   hit = 1'b1;
            2'b10:   hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Redirect target; the sum wraps modulo 2^DATA_WIDTH by construction
    function automatic logic [DATA_WIDTH-1:0] redirect_target(
        input logic [1:0]            sel,
        input logic [DATA_WIDTH-1:0] pce,
        input logic [DATA_WIDTH-1:0] imm,
        input logic [DATA_WIDTH-1:0] alu
    );
        logic [DATA_WIDTH-1:0] tgt;
        case (sel)
            2'b01:   tgt = pce + imm;
            2'b10:   tgt = alu & JALR_MASK;
            default: tgt = PC_ZERO;
        endcase
        return tgt;
    endfunction

    state_t                state_q,    state_d;
    logic [DATA_WIDTH-1:0] pc_q,       pc_d;
    logic [31:0]           instr_q,    instr_d;
    logic [DATA_WIDTH-1:0] pcd_q,      pcd_d;
    logic [DATA_WIDTH-1:0] pcplus4_q,  pcplus4_d;
    logic                  valid_q,    valid_d;
    logic                  fault_q,    fault_d;

    logic                  redirect_s;
    logic [DATA_WIDTH-1:0] target_s;
    logic                  misalign_s;
    logic [DATA_WIDTH-1:0] pc_plus4_s;

    // Redirect decode and alignment check of the candidate target
    always_comb begin
        redirect_s = is_redirect(PCSrc);
        target_s   = redirect_target(PCSrc, PCE, ImmExt, ALUResult);
        pc_plus4_s = pc_q + PC_STEP;
        if (redirect_s) begin
            misalign_s = target_s[1];
        end else begin
            misalign_s = 1'b0;
        end
    end

    // Controller next state, PC select and IF/ID update
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pcd_d     = pcd_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;

        case (state_q)
            BOOT: begin
                // One idle cycle after reset: PC holds, decode sees a bubble
                state_d = RUN;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end

            RUN: begin
                // IF/ID: a redirect squashes the wrong-path fetch just like FlushD,
                // and it wins over StallF so the bubble is never lost
                if (FlushD || redirect_s) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (StallF) begin
                    instr_d = instr_q;
                end else begin
                    instr_d   = InstrF;
                    pcd_d     = pc_q;
                    pcplus4_d = pc_plus4_s;
                    valid_d   = 1'b1;
                end

                // PC: redirect beats stall; a misaligned target freezes the PC
                if (redirect_s) begin
                    if (misalign_s) begin
                        state_d = FAULT;
                    end else begin
                        pc_d = target_s;
                    end
                end else if (StallF) begin
                    pc_d = pc_q;
                end else begin
                    pc_d = pc_plus4_s;
                end
            end

            FAULT: begin
                // Sticky until reset; keep feeding bubbles
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end

            default: begin
                // Unreachable encoding: park in the safe state
                state_d = FAULT;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        endcase

        if (state_d == FAULT) begin
            fault_d = 1'b1;
        end else begin
            fault_d = 1'b0;
        end
    end

    // State, PC and IF/ID registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            pcd_q     <= PC_ZERO;
            pcplus4_q <= PC_ZERO;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pcd_q     <= pcd_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
        end
    end

    assign PCF           = pc_q;
    assign InstrD        = instr_q;
    assign PCD           = pcd_q;
    assign PCPlus4D      = pcplus4_q;
    assign ValidD        = valid_q;
    assign MisalignFault = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage -- self-checking bench for fetch_stage.
// Directed scenarios plus a randomized run compared against a behavioural
// model of the fetch rules kept in this file.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, StallF, FlushD;
    logic [1:0]  PCSrc;
    logic [31:0] PCE, ImmExt, ALUResult, InstrF;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD, MisalignFault;

    int checks   = 0;
    int failures = 0;

    // Behavioural model
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
    logic        m_valid, m_boot, m_fault;

    always #5 clk = ~clk;

    // Instruction memory contents: a pattern derived from the address
    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a ^ 32'h5A5A_A5A5) + 32'h0000_0100;
    endfunction

    assign InstrF = pat(PCF);

    fetch_stage #(.DATA_WIDTH(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .StallF(StallF), .FlushD(FlushD), .PCSrc(PCSrc),
        .PCE(PCE), .ImmExt(ImmExt), .ALUResult(ALUResult), .InstrF(InstrF),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .MisalignFault(MisalignFault)
    );

    // Advance the model by one clock using the current inputs
    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        if (rst) begin
            m_pc = RPC; m_boot = 1'b1; m_fault = 1'b0;
            m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (m_fault) begin
            m_instr = NOP; m_valid = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_instr = NOP; m_valid = 1'b0;
        end else begin
            redir = (PCSrc == 2'd1) || (PCSrc == 2'd2);
            tgt   = (PCSrc == 2'd1) ? PCE + ImmExt : ALUResult - (ALUResult % 32'd2);
            if (FlushD || redir) begin
                m_instr = NOP; m_valid = 1'b0;
            end else if (!StallF) begin
                m_instr = pat(m_pc); m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            end
            if (redir) begin
                if ((tgt / 32'd2) % 32'd2 == 32'd1) m_fault = 1'b1;
                else m_pc = tgt;
            end else if (!StallF) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        rst = 1'b0; StallF = 1'b0; FlushD = 1'b0; PCSrc = 2'd0;
        PCE = 32'h0; ImmExt = 32'h0; ALUResult = 32'h0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst = 1'b1;
        tick(); tick();
        checks++; if (PCF !== RPC) begin failures++; $display("FAIL reset_pcf: got %h want %h", PCF, RPC); end
        checks++; if (InstrD !== NOP) begin failures++; $display("FAIL reset_instrd: got %h want %h", InstrD, NOP); end
        checks++; if ({PCD, PCPlus4D} !== 64'h0) begin failures++; $display("FAIL reset_pcd: got %h/%h want 0/0", PCD, PCPlus4D); end
        checks++; if ({ValidD, MisalignFault} !== 2'b00) begin failures++; $display("FAIL reset_flags: got %b%b want 00", ValidD, MisalignFault); end
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        // First cycle after reset (BOOT)
        checks++; if (PCF !== 32'h0) begin failures++; $display("FAIL run_pcf0: got %h want 0", PCF); end
        tick();
        checks++; if (PCF !== 32'h0 || ValidD !== 1'b0) begin failures++; $display("FAIL run_pcf1: got %h/%b want 0/0", PCF, ValidD); end
        tick();
        checks++; if (PCF !== 32'h4) begin failures++; $display("FAIL run_pcf2: got %h want 4", PCF); end
        checks++; if (ValidD !== 1'b1 || PCD !== 32'h0 || PCPlus4D !== 32'h4 || InstrD !== pat(32'h0)) begin
            failures++; $display("FAIL run_first_valid: got v=%b pcd=%h p4=%h i=%h want 1/0/4/%h", ValidD, PCD, PCPlus4D, InstrD, pat(32'h0));
        end
        tick();
        checks++; if (PCF !== 32'h8) begin failures++; $display("FAIL run_pcf3: got %h want 8", PCF); end
    endtask

    task automatic test_branch();
        PCSrc = 2'd1; PCE = 32'h10; ImmExt = 32'hFFFF_FFF8;
        tick();
        PCSrc = 2'd0;
        checks++; if (PCF !== 32'h8) begin failures++; $display("FAIL branch_pcf: got %h want 8", PCF); end
        checks++; if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h4) begin
            failures++; $display("FAIL branch_bubble: got v=%b i=%h pcd=%h want 0/13/4", ValidD, InstrD, PCD);
        end
    endtask

    task automatic test_jalr();
        PCSrc = 2'd2; ALUResult = 32'h0000_0101;
        tick();
        checks++; if (PCF !== 32'h100) begin failures++; $display("FAIL jalr_pcf: got %h want 100", PCF); end
        PCSrc = 2'd0;
        tick();
        PCSrc = 2'd2; ALUResult = 32'h0000_0102;
        tick();
        checks++; if (PCF !== 32'h104 || MisalignFault !== 1'b1 || ValidD !== 1'b0) begin
            failures++; $display("FAIL jalr_fault: got pcf=%h mf=%b v=%b want 104/1/0", PCF, MisalignFault, ValidD);
        end
        for (int i = 0; i < 5; i++) begin
            PCSrc = 2'($urandom_range(0, 3)); PCE = $urandom & 32'hFFFF_FFF0;
            StallF = 1'($urandom_range(0, 1)); FlushD = 1'($urandom_range(0, 1));
            tick();
            checks++; if (PCF !== 32'h104 || MisalignFault !== 1'b1 || ValidD !== 1'b0) begin
                failures++; $display("FAIL fault_sticky: got pcf=%h mf=%b v=%b want 104/1/0", PCF, MisalignFault, ValidD);
            end
        end
        // Reset in the same cycle as another misaligned redirect
        quiet_inputs();
        rst = 1'b1; PCSrc = 2'd2; ALUResult = 32'h0000_0102;
        tick();
        quiet_inputs();
        checks++; if ({PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignFault} !== {RPC, NOP, 64'h0, 2'b00}) begin
            failures++; $display("FAIL fault_reset: got pcf=%h i=%h pcd=%h p4=%h v=%b mf=%b want reset values", PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignFault);
        end
        tick(); tick();
        checks++; if (PCF !== 32'h4 || ValidD !== 1'b1 || PCD !== 32'h0) begin
            failures++; $display("FAIL fault_resume: got pcf=%h v=%b pcd=%h want 4/1/0", PCF, ValidD, PCD);
        end
    endtask

    task automatic test_stall();
        PCSrc = 2'd1; PCE = 32'h10; ImmExt = 32'hC;
        tick();
        PCSrc = 2'd0;
        tick();
        checks++; if (PCF !== 32'h20 || ValidD !== 1'b1 || PCD !== 32'h1C) begin
            failures++; $display("FAIL stall_setup: got pcf=%h v=%b pcd=%h want 20/1/1c", PCF, ValidD, PCD);
        end
        StallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (PCF !== 32'h20 || PCD !== 32'h1C || ValidD !== 1'b1 || InstrD !== pat(32'h1C) || PCPlus4D !== 32'h20) begin
                failures++; $display("FAIL stall_hold: got pcf=%h pcd=%h v=%b i=%h want 20/1c/1/%h", PCF, PCD, ValidD, InstrD, pat(32'h1C));
            end
        end
        StallF = 1'b0;
        tick();
        checks++; if (PCF !== 32'h24 || PCD !== 32'h20) begin failures++; $display("FAIL stall_release: got %h/%h want 24/20", PCF, PCD); end
    endtask

    task automatic test_edges();
        // Redirect during a stall is taken
        StallF = 1'b1; PCSrc = 2'd1; PCE = 32'h40; ImmExt = 32'h10;
        tick();
        StallF = 1'b0; PCSrc = 2'd0;
        checks++; if (PCF !== 32'h50 || ValidD !== 1'b0) begin failures++; $display("FAIL stall_redirect: got %h/%b want 50/0", PCF, ValidD); end
        tick();
        // Stall and flush together: PC holds, bubble, PCD held
        StallF = 1'b1; FlushD = 1'b1;
        tick();
        StallF = 1'b0; FlushD = 1'b0;
        checks++; if (PCF !== 32'h54 || ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h50) begin
            failures++; $display("FAIL stall_flush: got pcf=%h v=%b i=%h pcd=%h want 54/0/13/50", PCF, ValidD, InstrD, PCD);
        end
        // PC wrap at the top of the address space
        PCSrc = 2'd1; PCE = 32'hFFFF_FFF0; ImmExt = 32'hC;
        tick();
        PCSrc = 2'd0;
        tick();
        checks++; if (PCF !== 32'h0 || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || ValidD !== 1'b1) begin
            failures++; $display("FAIL pc_wrap: got pcf=%h pcd=%h p4=%h v=%b want 0/fffffffc/0/1", PCF, PCD, PCPlus4D, ValidD);
        end
        // Reset while stalled
        tick();
        StallF = 1'b1; rst = 1'b1;
        tick();
        checks++; if ({PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignFault} !== {RPC, NOP, 64'h0, 2'b00}) begin
            failures++; $display("FAIL stall_reset: got pcf=%h i=%h pcd=%h p4=%h v=%b mf=%b want reset values", PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignFault);
        end
        quiet_inputs();
        tick();
        checks++; if (PCF !== 32'h0 || ValidD !== 1'b0) begin failures++; $display("FAIL stall_reset_boot: got %h/%b want 0/0", PCF, ValidD); end
        tick();
        checks++; if (PCF !== 32'h4 || ValidD !== 1'b1) begin failures++; $display("FAIL stall_reset_run: got %h/%b want 4/1", PCF, ValidD); end
    endtask

    task automatic test_random();
        int sel;
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 29) == 0);
            StallF = ($urandom_range(0, 3) == 0);
            FlushD = ($urandom_range(0, 4) == 0);
            sel    = $urandom_range(0, 9);
            PCSrc  = (sel == 0) ? 2'd1 : (sel == 1) ? 2'd2 : (sel == 2) ? 2'd3 : 2'd0;
            PCE    = $urandom & 32'hFFFF_FFFC;
            ImmExt = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            ALUResult = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFD);
            tick();
            checks++;
            if ({PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignFault} !==
                {m_pc, m_instr, m_pcd, m_pc4, m_valid, m_fault}) begin
                failures++;
                $display("FAIL random[%0d]: got pcf=%h i=%h pcd=%h p4=%h v=%b mf=%b want %h %h %h %h %b %b",
                         i, PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignFault,
                         m_pc, m_instr, m_pcd, m_pc4, m_valid, m_fault);
            end
        end
    endtask

    initial begin
        quiet_inputs();
        test_reset();
        test_free_run();
        test_branch();
        test_jalr();
        test_stall();
        test_edges();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
